// File: rtl/countdown_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// countdown_pkg - shared FSM state, counter-op types and default sizing
// Revision: 1.0
// ----------------------------------------------------------------------------
package countdown_pkg;

  localparam int N_DEFAULT     = 128;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CNT_HOLD   = 3'd0,
    CNT_LOAD   = 3'd1,
    CNT_DEC    = 3'd2,
    CNT_CLEAR  = 3'd3,
    CNT_RELOAD = 3'd4
  } cnt_op_t;

endpackage
`default_nettype wire

// File: rtl/countdown_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// countdown_if - request/status bundle between a controller and countdown_seq
// Revision: 1.0
// ----------------------------------------------------------------------------
interface countdown_if
  import countdown_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             abort;
  logic             ack;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, load_val, enable, abort, ack,
    input  count, busy, tc, done
  );

  modport slave (
    input  start, load_val, enable, abort, ack,
    output count, busy, tc, done
  );

endinterface
`default_nettype wire

// File: rtl/countdown_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// countdown_reg - clamped load/hold/decrement/clear count register; the reload
// copy exists only when COUNTDOWN_AUTORELOAD_EN is defined.
// Revision: 1.0
// ----------------------------------------------------------------------------
module countdown_reg
  import countdown_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  cnt_op_t          op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(N - 1);

  if (N < 2 || N > (1 << WIDTH)) begin : g_bad_params
    $error("countdown_reg: N-1 must fit in WIDTH bits");
  end

  logic [WIDTH-1:0] clamped;
  assign clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_val;

  always_ff @(posedge clk) begin
    if (!rstn)
      reload_val <= '0;
    else if (op == CNT_LOAD)
      reload_val <= clamped;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      case (op)
        CNT_LOAD:  count <= clamped;
        CNT_DEC:   if (count != '0) count <= count - 1'b1;
        CNT_CLEAR: count <= '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        CNT_RELOAD: count <= reload_val;
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/countdown_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// countdown_seq - IDLE/RUN/DONE countdown sequencer; define
// COUNTDOWN_AUTORELOAD_EN for periodic (auto-reloading) mode.
// Revision: 1.0
// ----------------------------------------------------------------------------
module countdown_seq
  import countdown_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  countdown_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  cnt_op_t          op;
  logic             tc_q;
  logic             tc_nxt;
  logic [WIDTH-1:0] count;
  logic             count_is_one;

  assign count_is_one = (count == WIDTH'(1));

  countdown_reg #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_reg (
    .clk      (clk),
    .rstn     (rstn),
    .op       (op),
    .load_val (bus.load_val),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      tc_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      tc_q  <= tc_nxt;
    end
  end

  // abort outranks enable in RUN; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    op        = CNT_HOLD;
    tc_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.load_val == '0) begin
            state_nxt = DONE;
            op        = CNT_CLEAR;
            tc_nxt    = 1'b1;
          end else begin
            state_nxt = RUN;
            op        = CNT_LOAD;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          op        = CNT_CLEAR;
        end else if (bus.enable) begin
          if (count_is_one) begin
            tc_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            op     = CNT_RELOAD;
`else
            op        = CNT_CLEAR;
            state_nxt = DONE;
`endif
          end else begin
            op = CNT_DEC;
          end
        end
      end
      DONE: begin
        if (bus.ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.count = count;
  assign bus.busy  = (state == RUN);
  assign bus.tc    = tc_q;
  assign bus.done  = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_countdown_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_countdown_seq - directed and randomized self-checking bench for countdown_seq
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_countdown_seq;

  localparam int N     = 128;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rstn;

  countdown_if #(.WIDTH(WIDTH)) bus ();

  countdown_seq #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int busy_cnt;
  int tc_cnt;

  // model: phase 0 = waiting, 1 = counting, 2 = finished
  int m_phase  = 0;
  int m_count  = 0;
  int m_period = 0;
  bit m_tc     = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int ph;
    int cnt;
    int per;
    bit t;
    ph  = m_phase;
    cnt = m_count;
    per = m_period;
    t   = 1'b0;
    if (!rstn) begin
      ph  = 0;
      cnt = 0;
    end else if (ph == 0) begin
      if (bus.start) begin
        if (bus.load_val == 0) begin
          ph  = 2;
          cnt = 0;
          t   = 1'b1;
        end else begin
          cnt = (int'(bus.load_val) > N - 1) ? N - 1 : int'(bus.load_val);
          per = cnt;
          ph  = 1;
        end
      end
    end else if (ph == 1) begin
      if (bus.abort) begin
        ph  = 0;
        cnt = 0;
      end else if (bus.enable) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          t = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          cnt = per;
`else
          ph = 2;
`endif
        end
      end
    end else if (bus.ack) begin
      ph = 0;
    end
    m_phase  <= ph;
    m_count  <= cnt;
    m_period <= per;
    m_tc     <= t;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_count", int'(bus.count), m_count);
      check("cmp_busy",  int'(bus.busy),  int'(m_phase == 1));
      check("cmp_tc",    int'(bus.tc),    int'(m_tc));
      check("cmp_done",  int'(bus.done),  int'(m_phase == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int l);
    bus.start    = 1'b1;
    bus.load_val = WIDTH'(l);
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_count"}, int'(bus.count), 0);
    check({name, "_busy"},  int'(bus.busy),  0);
    check({name, "_tc"},    int'(bus.tc),    0);
    check({name, "_done"},  int'(bus.done),  0);
  endtask

  initial begin
    rstn         = 1'b0;
    bus.start    = 1'b0;
    bus.load_val = '0;
    bus.enable   = 1'b0;
    bus.abort    = 1'b0;
    bus.ack      = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    check_quiet("reset");
    rstn = 1'b1;

`ifndef COUNTDOWN_AUTORELOAD_EN
    // reset in the middle of a run
    bus.enable = 1'b1;
    go(50);
    repeat (10) tick();
    check("midrun_count", int'(bus.count), 40);
    rstn = 1'b0;
    tick();
    check_quiet("midrun_rst");
    rstn = 1'b1;
    tick();
    check_quiet("after_rst");

    // one-shot of 5
    go(5);
    check("os_load", int'(bus.count), 5);
    busy_cnt = int'(bus.busy);
    for (int i = 4; i >= 0; i--) begin
      tick();
      check("os_count", int'(bus.count), i);
      busy_cnt += int'(bus.busy);
    end
    check("os_tc", int'(bus.tc), 1);
    check("os_done", int'(bus.done), 1);
    check("os_busy_cycles", busy_cnt, 5);
    tick();
    check("os_tc_once", int'(bus.tc), 0);
    check("os_done_held", int'(bus.done), 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_quiet("os_ack");

    // clamp and stall
    go(200);
    check("clamp_load", int'(bus.count), 127);
    busy_cnt = int'(bus.busy);
    repeat (9) begin
      tick();
      busy_cnt += int'(bus.busy);
    end
    check("clamp_pre_stall", int'(bus.count), 118);
    bus.enable = 1'b0;
    repeat (3) begin
      tick();
      busy_cnt += int'(bus.busy);
      check("stall_hold", int'(bus.count), 118);
    end
    bus.enable = 1'b1;
    for (int k = 0; k < 300 && !bus.done; k++) begin
      tick();
      busy_cnt += int'(bus.busy);
    end
    check("clamp_done", int'(bus.done), 1);
    check("clamp_run_cycles", busy_cnt, 130);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;

    // abort beats enable
    go(30);
    repeat (10) tick();
    check("abort_at", int'(bus.count), 20);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_quiet("abort");
    tick();
    check_quiet("abort_after");

    // start alongside ack in DONE is dropped
    go(1);
    check("one_busy", int'(bus.busy), 1);
    tick();
    check("one_done", int'(bus.done), 1);
    bus.ack      = 1'b1;
    bus.start    = 1'b1;
    bus.load_val = 8'd9;
    tick();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    check_quiet("ack_start");
    tick();
    check_quiet("no_reload");

    // zero load
    bus.enable = 1'b0;
    go(0);
    check("zero_done", int'(bus.done), 1);
    check("zero_tc", int'(bus.tc), 1);
    check("zero_busy", int'(bus.busy), 0);
    tick();
    check("zero_tc_once", int'(bus.tc), 0);
    check("zero_busy2", int'(bus.busy), 0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
`else
    // periodic mode, period 4
    bus.enable = 1'b1;
    go(4);
    check("ar_load", int'(bus.count), 4);
    tc_cnt = 0;
    repeat (12) begin
      tick();
      tc_cnt += int'(bus.tc);
      check("ar_no_done", int'(bus.done), 0);
    end
    check("ar_tc_count", tc_cnt, 3);
    check("ar_reloaded", int'(bus.count), 4);
    check("ar_busy", int'(bus.busy), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_quiet("ar_abort");
`endif

    // randomized traffic, checked cycle by cycle against the model
    repeat (3000) begin
      rstn      = ($urandom_range(0, 99) != 0);
      bus.start = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0:       bus.load_val = '0;
        1:       bus.load_val = WIDTH'($urandom_range(128, 255));
        2:       bus.load_val = WIDTH'($urandom_range(1, 12));
        default: bus.load_val = WIDTH'($urandom);
      endcase
      bus.enable = ($urandom_range(0, 3) != 0);
      bus.abort  = ($urandom_range(0, 29) == 0);
      bus.ack    = ($urandom_range(0, 2) == 0);
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/countdown_seq.md
COUNTDOWN_SEQ -- requirements
Module: countdown_seq

Interface
REQ-001 SHALL have parameter N, default 128: maximum count span; loads are clamped to N-1.
REQ-002 SHALL have parameter WIDTH, default 8: count width; N-1 SHALL fit in WIDTH bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  load-and-run request, sampled in IDLE only.
REQ-006 SHALL have port load_val  input  WIDTH  initial count, sampled with start.
REQ-007 SHALL have port enable  input  1  decrement permission while in RUN.
REQ-008 SHALL have port abort  input  1  cancels a run in progress.
REQ-009 SHALL have port ack  input  1  consumer acknowledge of done.
REQ-010 SHALL have port count  output  WIDTH  current remaining count, registered.
REQ-011 SHALL have port busy  output  1  high while in RUN, registered.
REQ-012 SHALL have port tc  output  1  one-cycle terminal-count pulse, registered.
REQ-013 SHALL have port done  output  1  sticky completion flag, high in DONE, registered.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE with start=1 SHALL load count<=min(load_val, N-1) and enter RUN; busy=1 the following cycle.
REQ-016 IDLE with start=1 and load_val=0 SHALL enter DONE directly with count=0, tc=1 for one cycle, busy staying 0.
REQ-017 RUN with enable=1 and count>1 SHALL decrement count by 1 per cycle; enable=0 SHALL hold count.
REQ-018 RUN with enable=1 and count=1 SHALL set count<=0, pulse tc for exactly one cycle, clear busy, enter DONE.
REQ-019 From start edge, with enable held high and load L (1..N-1), done SHALL rise exactly L cycles after busy rises.
REQ-020 RUN with abort=1 SHALL enter IDLE, count<=0, busy<=0, no tc, no done; abort SHALL take priority over enable.
REQ-021 abort in IDLE or DONE SHALL be ignored.
REQ-022 start outside IDLE SHALL be ignored; no re-load mid-run.
REQ-023 DONE SHALL hold done=1 and count=0 until ack=1, then enter IDLE with done<=0.
REQ-024 DONE with ack=1 and start=1 in the same cycle: ack SHALL take effect, start SHALL be ignored.
REQ-025 count SHALL never underflow below 0 nor exceed N-1.

Reset
REQ-026 rstn=0 at a clock edge SHALL force IDLE, count=0, busy=0, tc=0, done=0, from any state including mid-RUN.
REQ-027 rstn=0 SHALL override start, abort, enable and ack in the same cycle.

Configuration
REQ-028 Macro COUNTDOWN_AUTORELOAD_EN SHALL select periodic mode.
REQ-029 With COUNTDOWN_AUTORELOAD_EN defined: reaching 0 in RUN SHALL pulse tc, reload count with the last loaded value (clamped), remain in RUN with busy=1; done SHALL never assert; exit only via abort or reset.
REQ-030 Without COUNTDOWN_AUTORELOAD_EN: one-shot behaviour per REQ-018 and REQ-023; no reload register SHALL be synthesized.

Structure
REQ-031 Package countdown_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and default constants for N and WIDTH.
REQ-032 Sub-module countdown_reg SHALL implement the clamped load/hold/decrement/reload register; FSM SHALL stay in countdown_seq.

Verification
REQ-033 Reset mid-run: start with load_val=50, 10 enabled cycles, rstn=0 -> next cycle count=0, busy=0, done=0, state IDLE.
REQ-034 One-shot: load_val=5, enable held 1 -> busy for 5 cycles, count 5,4,3,2,1,0, tc pulse once, done held until ack, IDLE next cycle after ack.
REQ-035 Stall and clamp: load_val=200 (N=128) -> count=127; enable low 3 cycles mid-run -> count held, total RUN time 127+3 cycles.
REQ-036 Abort/priority: abort and enable both high at count=20 -> IDLE, count=0, no tc, no done; start in DONE with ack -> IDLE, no reload.
REQ-037 Zero load: start with load_val=0 -> DONE next cycle, tc=1 one cycle, busy never high.
REQ-038 COUNTDOWN_AUTORELOAD_EN build: load_val=4, enable held -> tc every 4 cycles for 3 periods, done stays 0, abort -> IDLE.
